// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, flag indices and sequencer states shared by the ALU and its input sequencer.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SHOW} state_t;

    function automatic logic op_illegal(input logic [3:0] op, input logic b_zero);
        return op > OP_SHR || ((op == OP_DIV || op == OP_MOD) && b_zero);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, optional debounce (ALU_SEQ_DEBOUNCE_EN) and press-edge detect.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    logic s1, s2, level;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic level_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, s2, level, level_d} <= 4'b1111;
            cnt <= '0;
            press <= 1'b0;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            level_d <= level;
            press <= level_d & ~level;
            // level only follows the synchronized input after it disagrees for DEBOUNCE_CYCLES in a row
            if (s2 == level) cnt <= '0;
            else if (cnt == LAST) begin
                level <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, s2, level} <= 3'b111;
            press <= 1'b0;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            level <= s2;
            press <= level & ~s2;
        end
    end
`endif
endmodule

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: loads A, B and opcode one button press at a time, then captures the ALU result.
// Button debounce is built in only when ALU_SEQ_DEBOUNCE_EN is defined.
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic [3:0]   op_sw,
    input  logic         btn_n,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [3:0]   op_o,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic         err,
    output logic [2:0]   stage,
    output logic         done
);
    logic press, ill;
    state_t state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(clk),
        .rst_n(rst_n),
        .btn_n(btn_n),
        .press(press)
    );

    assign ill = op_illegal(op_o, b_o == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_A;
            a_o <= '0;
            b_o <= '0;
            op_o <= '0;
            result_q <= '0;
            flags_q <= '0;
            err <= 1'b0;
            stage <= 3'b001;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_A: if (press) begin
                    a_o <= sw;
                    state <= S_B;
                    stage <= 3'b010;
                end
                S_B: if (press) begin
                    b_o <= sw;
                    state <= S_OP;
                    stage <= 3'b100;
                end
                S_OP: if (press) begin
                    op_o <= op_sw;
                    state <= S_EXEC;
                    stage <= 3'b000;
                end
                S_EXEC: begin
                    // illegal operations report a forced zero result with only Z set
                    result_q <= ill ? '0 : alu_result;
                    flags_q <= ill ? 4'(1 << FLAG_Z) : alu_flags;
                    err <= ill;
                    done <= 1'b1;
                    state <= S_SHOW;
                end
                S_SHOW: if (press) begin
                    state <= S_A;
                    stage <= 3'b001;
                end
                default: begin
                    state <= S_A;
                    stage <= 3'b001;
                end
            endcase
        end
    end
endmodule
